// File: rtl/buffer_chain_rx.sv
// Receive-end terminator of a buffering chain: DEPTH-entry circular FIFO between two valid/ready ports.
// Optional parity screening on the input word is enabled by defining BUFFER_CHAIN_RX_PARITY_EN.
module buffer_chain_rx #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_par,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [AW:0]      count,
   output logic             ovf,
   output logic             par_err
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic             run;
   logic             ovf_q;
   logic             full;
   logic             empty;
   logic             accept;
   logic             push;
   logic             pop;
   logic             par_ok;

   assign full      = (cnt == FULL);
   assign empty     = (cnt == '0);
   // run holds in_ready low until the first edge after reset release
   assign in_ready  = run && !full;
   assign out_valid = !empty;
   assign accept    = in_valid && in_ready;
   assign push      = accept && par_ok;
   assign pop       = out_valid && out_ready;
   assign out_data  = empty ? '0 : mem[rp];
   assign count     = cnt;
   assign ovf       = ovf_q;

`ifdef BUFFER_CHAIN_RX_PARITY_EN
   logic perr_q;

   assign par_ok  = ~^{in_data, in_par};
   assign par_err = perr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
      end else if (accept && !par_ok) begin
         perr_q <= 1'b1;
      end
   end
`else
   logic unused_par;

   assign unused_par = in_par;
   assign par_ok     = 1'b1;
   assign par_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run   <= 1'b0;
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else begin
         run <= 1'b1;
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (in_valid && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_buffer_chain_rx.sv
// Directed self-checking bench for buffer_chain_rx (DEPTH=4, WIDTH=8), both parity build variants.
module tb_buffer_chain_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_par;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic       ovf;
   logic       par_err;

   int checks = 0;
   int errors = 0;

   buffer_chain_rx #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_par(in_par), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count), .ovf(ovf), .par_err(par_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_par = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_par_err", 32'(par_err), 0);
      step(); step();
      rst_n = 1'b1;
      step();
      chk("ready_after_release", 32'(in_ready), 1);

      // reset mid-stream
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'hA1 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      chk("mid_count3", 32'(count), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_ovf", 32'(ovf), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_ready", 32'(in_ready), 1);
      in_valid = 1'b1; in_data = 8'h5A;
      step();
      in_valid = 1'b0;
      chk("mid_5a_data", 32'(out_data), 32'h5A);
      chk("mid_5a_count", 32'(count), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("mid_drain_count", 32'(count), 0);

      // fill to full, overflow attempt, drain
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_data = 8'(i);
         step();
         chk("fill_count", 32'(count), 32'(i));
      end
      chk("full_in_ready", 32'(in_ready), 0);
      in_data = 8'h05;
      step();
      in_valid = 1'b0;
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", 32'(out_valid), 1);
         chk("drain_data", 32'(out_data), 32'(i));
         step();
         if (i == 1) chk("ready_after_pop", 32'(in_ready), 1);
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 0);
      chk("drain_count", 32'(count), 0);

      // simultaneous push/pop at count=2 across pointer wrap
      in_valid = 1'b1;
      in_data = 8'h20; step();
      in_data = 8'h21; step();
      chk("sim_pre_count", 32'(count), 2);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_data = 8'h22 + 8'(k);
         chk("sim_data", 32'(out_data), 32'h20 + 32'(k));
         step();
         chk("sim_count", 32'(count), 2);
      end
      in_valid = 1'b0;
      chk("sim_tail0", 32'(out_data), 32'h2A);
      step();
      chk("sim_tail1", 32'(out_data), 32'h2B);
      step();
      out_ready = 1'b0;
      chk("sim_end_count", 32'(count), 0);

      // back-to-back streaming
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1; in_data = 8'h10 + 8'(k);
         step();
         chk("stream_data", 32'(out_data), 32'h10 + 32'(k));
         chk("stream_count", 32'(count), 1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_end_count", 32'(count), 0);

      // empty with out_ready asserted
      for (int k = 0; k < 5; k++) begin
         step();
         chk("empty_valid", 32'(out_valid), 0);
         chk("empty_count", 32'(count), 0);
      end
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h77;
      step();
      in_valid = 1'b0;
      chk("empty_then_push", 32'(out_data), 32'h77);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("empty_then_pop", 32'(count), 0);

      // parity screening
      in_valid = 1'b1; in_data = 8'h03; in_par = 1'b0;
      step();
      chk("par_c1", 32'(count), 1);
      chk("par_e1", 32'(par_err), 0);
      in_par = 1'b1;
      step();
      in_data = 8'h07;
      step();
      in_valid = 1'b0; in_par = 1'b0;
`ifdef BUFFER_CHAIN_RX_PARITY_EN
      chk("par_err_set", 32'(par_err), 1);
      chk("par_count", 32'(count), 2);
      out_ready = 1'b1;
      chk("par_out0", 32'(out_data), 32'h03); step();
      chk("par_out1", 32'(out_data), 32'h07); step();
`else
      chk("par_err_tied", 32'(par_err), 0);
      chk("par_count", 32'(count), 3);
      out_ready = 1'b1;
      chk("par_out0", 32'(out_data), 32'h03); step();
      chk("par_out1", 32'(out_data), 32'h03); step();
      chk("par_out2", 32'(out_data), 32'h07); step();
`endif
      out_ready = 1'b0;
      chk("par_end_count", 32'(count), 0);
      chk("ovf_sticky", 32'(ovf), 1);

      #2 rst_n = 1'b0;
      #1;
      chk("final_rst_ovf", 32'(ovf), 0);
      chk("final_rst_par_err", 32'(par_err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
